// File: rtl/phv_action_aligner_if.sv
// Handshake and data bundle between the lookup/parser side, the aligner and the action engine.
//   phv_in/phv_valid_in/phv_ready_out : PHV entering the aligner (ready is combinational)
//   action_in/action_valid_in         : action word returned by the lookup engine
//   phv_out/phv_valid_out             : aligned PHV to the action engine
//   action_out/action_valid_out       : aligned action to the action engine
// The slave modport is the aligner's view; the master modport is the surrounding logic's view.
interface phv_action_aligner_if #(
    parameter int unsigned PHV_LEN = 1124,
    parameter int unsigned ACT_LEN = 25
);
    localparam int unsigned ACT_W = ACT_LEN * 25;

    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic               phv_ready_out;
    logic [ACT_W-1:0]   action_in;
    logic               action_valid_in;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic [ACT_W-1:0]   action_out;
    logic               action_valid_out;

    modport slave (
        input  phv_in,
        input  phv_valid_in,
        output phv_ready_out,
        input  action_in,
        input  action_valid_in,
        output phv_out,
        output phv_valid_out,
        output action_out,
        output action_valid_out
    );

    modport master (
        output phv_in,
        output phv_valid_in,
        input  phv_ready_out,
        output action_in,
        output action_valid_in,
        input  phv_out,
        input  phv_valid_out,
        input  action_out,
        input  action_valid_out
    );
endinterface

// File: rtl/phv_action_aligner.sv
// PHV / action aligner: holds each PHV in a circular buffer until the lookup engine
// returns its action word, then presents the pair to the action engine as one beat
// with both valids asserted together, one cycle after the action arrives.
// Ports:
//   clk           single clock
//   rst_n         synchronous reset, active HIGH (legacy name kept)
//   bus           handshake/data bundle (slave view), see phv_action_aligner_if
//   pending_cnt   number of PHVs currently buffered (0..DEPTH)
//   err_overflow  sticky: a PHV was dropped because the buffer was full
//   err_underflow sticky: an action arrived with no PHV to pair with
module phv_action_aligner #(
    parameter int          STAGE   = 0,
    parameter int unsigned PHV_LEN = 1124,
    parameter int unsigned ACT_LEN = 25,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    phv_action_aligner_if.slave bus,
    output logic [ADDR_W:0]     pending_cnt,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam int unsigned ACT_W = ACT_LEN * 25;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit CFG_OK = (DEPTH >= 2) && (DEPTH == (32'd1 << ADDR_W)) && (STAGE >= 0);

    // Configuration guard: pointer wrap relies on DEPTH being exactly 2**ADDR_W.
    if (!CFG_OK) begin : g_cfg_err
        $error("phv_action_aligner: DEPTH must equal 2**ADDR_W and be at least 2");
    end

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;

    logic empty_c;
    logic full_c;
    logic ready_c;
    logic bypass_c;
    logic push_c;
    logic pop_c;
    logic overflow_c;
    logic underflow_c;

    // Event decode for this cycle.
    always_comb begin
        empty_c     = 1'b0;
        full_c      = 1'b0;
        ready_c     = 1'b0;
        bypass_c    = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        overflow_c  = 1'b0;
        underflow_c = 1'b0;

        empty_c = (pending_cnt == CNT_W'(0));
        full_c  = (pending_cnt == CNT_W'(DEPTH));
        // A pop in the same cycle frees the slot the incoming PHV needs.
        ready_c = !full_c || bus.action_valid_in;

        // Empty buffer with both strobes: pair directly, never touch storage.
        bypass_c    = empty_c && bus.phv_valid_in && bus.action_valid_in;
        push_c      = bus.phv_valid_in && ready_c && !bypass_c;
        pop_c       = bus.action_valid_in && !empty_c;
        overflow_c  = bus.phv_valid_in && !ready_c;
        underflow_c = bus.action_valid_in && empty_c && !bus.phv_valid_in;
    end

    assign bus.phv_ready_out = ready_c;

    // PHV storage; contents need no reset because pointers and count gate every read.
    // When full with push+pop, wr_ptr == rd_ptr: the read below sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n && push_c) begin
            mem[wr_ptr] <= bus.phv_in;
        end
    end

    // Pointers and occupancy (rst_n is active high).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending_cnt <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
                2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

    // Aligned output beat: single-cycle valids, data holds between beats.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.phv_out          <= '0;
            bus.action_out       <= '0;
            bus.phv_valid_out    <= 1'b0;
            bus.action_valid_out <= 1'b0;
        end else begin
            bus.phv_valid_out    <= pop_c || bypass_c;
            bus.action_valid_out <= pop_c || bypass_c;
            if (pop_c) begin
                bus.phv_out    <= mem[rd_ptr];
                bus.action_out <= ACT_W'(bus.action_in);
            end else if (bypass_c) begin
                bus.phv_out    <= bus.phv_in;
                bus.action_out <= ACT_W'(bus.action_in);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (overflow_c) begin
                err_overflow <= 1'b1;
            end
            if (underflow_c) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phv_action_aligner.sv
// Directed bench for phv_action_aligner: reset, in-order pairing, bypass,
// full/overflow, underflow, wrap-around streaming and reset mid-operation.
module tb_phv_action_aligner;

    localparam int unsigned PHV_LEN = 1124;
    localparam int unsigned ACT_LEN = 25;
    localparam int unsigned ACT_W   = ACT_LEN * 25;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = 3;

    typedef logic [PHV_LEN-1:0] vec_t;
    typedef logic [ACT_W-1:0]   act_t;

    logic            clk;
    logic            rst_n;
    logic [ADDR_W:0] pending_cnt;
    logic            err_overflow;
    logic            err_underflow;

    int nvec;
    int nerr;

    phv_action_aligner_if #(.PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN)) bus ();

    phv_action_aligner #(
        .STAGE   (0),
        .PHV_LEN (PHV_LEN),
        .ACT_LEN (ACT_LEN),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .pending_cnt   (pending_cnt),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Apply one cycle of stimulus; returns 1 ns after the edge with inputs idle.
    task automatic drive(input logic pv, input logic [31:0] pd, input logic av, input logic [31:0] ad);
        bus.phv_valid_in    = pv;
        bus.phv_in          = vec_t'(pd);
        bus.action_valid_in = av;
        bus.action_in       = act_t'(ad);
        @(posedge clk);
        #1;
        bus.phv_valid_in    = 1'b0;
        bus.phv_in          = '0;
        bus.action_valid_in = 1'b0;
        bus.action_in       = '0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] phv, input logic [31:0] act);
        check({tag, ".pv"}, vec_t'(bus.phv_valid_out), vec_t'(1'b1));
        check({tag, ".av"}, vec_t'(bus.action_valid_out), vec_t'(1'b1));
        check({tag, ".phv"}, bus.phv_out, vec_t'(phv));
        check({tag, ".act"}, vec_t'(bus.action_out), vec_t'(act));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        bus.phv_valid_in    = 1'b0;
        bus.phv_in          = '0;
        bus.action_valid_in = 1'b0;
        bus.action_in       = '0;

        // Reset then idle.
        do_reset(2);
        check("rst.pv",    vec_t'(bus.phv_valid_out), '0);
        check("rst.av",    vec_t'(bus.action_valid_out), '0);
        check("rst.phv",   bus.phv_out, '0);
        check("rst.act",   vec_t'(bus.action_out), '0);
        check("rst.cnt",   vec_t'(pending_cnt), '0);
        check("rst.ovf",   vec_t'(err_overflow), '0);
        check("rst.unf",   vec_t'(err_underflow), '0);
        check("rst.ready", vec_t'(bus.phv_ready_out), vec_t'(1'b1));

        // In-order pairing: PHVs 1,2,3 then actions A,B,C after two idle cycles.
        drive(1'b1, 32'h1, 1'b0, 32'h0);
        drive(1'b1, 32'h2, 1'b0, 32'h0);
        drive(1'b1, 32'h3, 1'b0, 32'h0);
        check("ord.cnt3", vec_t'(pending_cnt), vec_t'(3));
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("ord.idle_pv", vec_t'(bus.phv_valid_out), '0);
        drive(1'b0, 32'h0, 1'b1, 32'hA);
        check_beat("ord.b0", 32'h1, 32'hA);
        check("ord.cnt2", vec_t'(pending_cnt), vec_t'(2));
        drive(1'b0, 32'h0, 1'b1, 32'hB);
        check_beat("ord.b1", 32'h2, 32'hB);
        check("ord.cnt1", vec_t'(pending_cnt), vec_t'(1));
        drive(1'b0, 32'h0, 1'b1, 32'hC);
        check_beat("ord.b2", 32'h3, 32'hC);
        check("ord.cnt0", vec_t'(pending_cnt), '0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("ord.pulse_pv", vec_t'(bus.phv_valid_out), '0);
        check("ord.pulse_av", vec_t'(bus.action_valid_out), '0);
        check("ord.hold_phv", bus.phv_out, vec_t'(32'h3));
        check("ord.hold_act", vec_t'(bus.action_out), vec_t'(32'hC));

        // Bypass on an empty buffer.
        drive(1'b1, 32'h55, 1'b1, 32'h77);
        check_beat("byp", 32'h55, 32'h77);
        check("byp.cnt", vec_t'(pending_cnt), '0);

        // Fill to DEPTH, then a ninth PHV with no action is dropped.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 32'h0);
        end
        check("full.cnt", vec_t'(pending_cnt), vec_t'(8));
        check("full.ready", vec_t'(bus.phv_ready_out), '0);
        drive(1'b1, 32'h999, 1'b0, 32'h0);
        check("ovf.flag", vec_t'(err_overflow), vec_t'(1'b1));
        check("ovf.cnt", vec_t'(pending_cnt), vec_t'(8));
        check("ovf.ready", vec_t'(bus.phv_ready_out), '0);
        check("ovf.pv", vec_t'(bus.phv_valid_out), '0);

        // Push with simultaneous action while full: ready rises combinationally.
        bus.action_valid_in = 1'b1;
        #1;
        check("full.ready_pop", vec_t'(bus.phv_ready_out), vec_t'(1'b1));
        drive(1'b1, 32'h200, 1'b1, 32'hD);
        check_beat("full.swap", 32'h101, 32'hD);
        check("full.swap_cnt", vec_t'(pending_cnt), vec_t'(8));

        // Drain: 0x102..0x108 then the PHV accepted while full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'hE0 + 32'(i));
            check_beat($sformatf("drain%0d", i), (i < 7) ? 32'h102 + 32'(i) : 32'h200, 32'hE0 + 32'(i));
        end
        check("drain.cnt", vec_t'(pending_cnt), '0);
        check("drain.ovf_sticky", vec_t'(err_overflow), vec_t'(1'b1));

        // Underflow: action with nothing buffered and no PHV.
        drive(1'b0, 32'h0, 1'b1, 32'h9);
        check("unf.pv", vec_t'(bus.phv_valid_out), '0);
        check("unf.av", vec_t'(bus.action_valid_out), '0);
        check("unf.flag", vec_t'(err_underflow), vec_t'(1'b1));
        check("unf.hold_act", vec_t'(bus.action_out), vec_t'(32'hE7));
        check("unf.cnt", vec_t'(pending_cnt), '0);
        drive(1'b1, 32'h42, 1'b1, 32'h43);
        check_beat("unf.byp", 32'h42, 32'h43);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("unf.sticky", vec_t'(err_underflow), vec_t'(1'b1));

        do_reset(1);
        check("rst2.ovf", vec_t'(err_overflow), '0);
        check("rst2.unf", vec_t'(err_underflow), '0);

        // Stream 20 PHVs with actions lagging by 3 cycles; pointers wrap twice.
        for (int t = 0; t < 23; t++) begin
            int pushes;
            int pops;
            drive(t < 20, 32'h1000 + 32'(t), t >= 3, 32'h500 + 32'(t - 3));
            if (t >= 3) begin
                check_beat($sformatf("strm%0d", t - 3), 32'h1000 + 32'(t - 3), 32'h500 + 32'(t - 3));
            end
            pushes = (t + 1 < 20) ? t + 1 : 20;
            pops   = (t >= 3) ? t - 2 : 0;
            check($sformatf("strm.cnt%0d", t), vec_t'(pending_cnt), vec_t'(pushes - pops));
        end
        check("strm.unf", vec_t'(err_underflow), '0);
        check("strm.ovf", vec_t'(err_overflow), '0);

        // Reset with three PHVs pending discards them.
        drive(1'b1, 32'h31, 1'b0, 32'h0);
        drive(1'b1, 32'h32, 1'b0, 32'h0);
        drive(1'b1, 32'h33, 1'b0, 32'h0);
        check("mid.cnt3", vec_t'(pending_cnt), vec_t'(3));
        do_reset(1);
        check("mid.cnt0", vec_t'(pending_cnt), '0);
        check("mid.pv", vec_t'(bus.phv_valid_out), '0);
        drive(1'b0, 32'h0, 1'b1, 32'h61);
        check("mid.stale_pv", vec_t'(bus.phv_valid_out), '0);
        check("mid.stale_phv", bus.phv_out, '0);
        check("mid.unf", vec_t'(err_underflow), vec_t'(1'b1));
        drive(1'b0, 32'h0, 1'b1, 32'h62);
        check("mid.stale_pv2", vec_t'(bus.phv_valid_out), '0);
        check("mid.cnt_end", vec_t'(pending_cnt), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
